// File: rtl/mem_access_unit.sv
// Memory-stage controller: turns EX/MEM operations into data-memory accesses
// (aligned loads with extension, read-modify-write sub-word stores) and a registered MEM/WB result.
module mem_access_unit #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              res,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              ex_memrd,
    input  logic              ex_memwr,
    input  logic [1:0]        ex_size,
    input  logic              ex_unsigned,
    input  logic [31:0]       ex_addr,
    input  logic [DATA_W-1:0] ex_wdata,
    input  logic [4:0]        ex_rd,
    input  logic              ex_regwrite,
    output logic              mem_wr,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_valid,
    output logic [31:0]       wb_data,
    output logic [4:0]        wb_rd,
    output logic              wb_regwrite,
    output logic              wb_fault
);

    typedef enum logic [2:0] {
        IDLE,
        LD_REQ,
        LD_WAIT,
        RMW_REQ,
        RMW_WAIT,
        RMW_WR
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t              state, state_n;
    logic [31:0]         op_addr, op_addr_n;
    logic [1:0]          op_size, op_size_n;
    logic                op_unsigned, op_unsigned_n;
    logic [15:0]         op_wdata, op_wdata_n;
    logic [4:0]          op_rd, op_rd_n;
    logic                op_regwrite, op_regwrite_n;

    logic                mem_wr_n, mem_rd_n, wb_valid_n, wb_regwrite_n, wb_fault_n;
    logic [ADDR_W-1:0]   mem_addr_n;
    logic [DATA_W-1:0]   mem_wdata_n;
    logic [31:0]         wb_data_n;
    logic [4:0]          wb_rd_n;

    logic                is_mem, fault;
    logic [DATA_W-1:0]   lane_shift, load_ext, merged;

    assign in_ready = (state == IDLE);

    // Alignment and range faults only apply to real memory operations.
    assign is_mem = ex_memrd | ex_memwr;
    assign fault  = (ex_memrd & ex_memwr)
                  | (is_mem & ((ex_size == 2'b11)
                             | (ex_addr[31:ADDR_W+2] != '0)
                             | ((ex_size == SZ_HALF) & ex_addr[0])
                             | ((ex_size == SZ_WORD) & (ex_addr[1:0] != 2'b00))));

    assign lane_shift = mem_rdata >> {op_addr[1:0], 3'b000};

    always_comb begin
        load_ext = mem_rdata;
        merged   = mem_rdata;
        case (op_size)
            SZ_BYTE: begin
                load_ext = op_unsigned ? {{(DATA_W-8){1'b0}}, lane_shift[7:0]}
                                       : {{(DATA_W-8){lane_shift[7]}}, lane_shift[7:0]};
                merged[{op_addr[1:0], 3'b000} +: 8] = op_wdata[7:0];
            end
            SZ_HALF: begin
                load_ext = op_unsigned ? {{(DATA_W-16){1'b0}}, lane_shift[15:0]}
                                       : {{(DATA_W-16){lane_shift[15]}}, lane_shift[15:0]};
                merged[{op_addr[1], 4'b0000} +: 16] = op_wdata[15:0];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_n       = state;
        op_addr_n     = op_addr;
        op_size_n     = op_size;
        op_unsigned_n = op_unsigned;
        op_wdata_n    = op_wdata;
        op_rd_n       = op_rd;
        op_regwrite_n = op_regwrite;
        mem_wr_n      = 1'b0;
        mem_rd_n      = 1'b0;
        mem_addr_n    = mem_addr;
        mem_wdata_n   = mem_wdata;
        wb_valid_n    = 1'b0;
        wb_data_n     = wb_data;
        wb_rd_n       = wb_rd;
        wb_regwrite_n = 1'b0;
        wb_fault_n    = 1'b0;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    op_addr_n     = ex_addr;
                    op_size_n     = ex_size;
                    op_unsigned_n = ex_unsigned;
                    op_wdata_n    = ex_wdata[15:0];
                    op_rd_n       = ex_rd;
                    op_regwrite_n = ex_regwrite;
                    if (fault) begin
                        wb_valid_n = 1'b1;
                        wb_fault_n = 1'b1;
                        wb_data_n  = ex_addr;
                        wb_rd_n    = ex_rd;
                    end else if (ex_memrd) begin
                        mem_rd_n   = 1'b1;
                        mem_addr_n = ex_addr[ADDR_W+1:2];
                        state_n    = LD_REQ;
                    end else if (ex_memwr && ex_size == SZ_WORD) begin
                        mem_wr_n    = 1'b1;
                        mem_addr_n  = ex_addr[ADDR_W+1:2];
                        mem_wdata_n = ex_wdata;
                        wb_valid_n  = 1'b1;
                        wb_data_n   = ex_addr;
                        wb_rd_n     = ex_rd;
                    end else if (ex_memwr) begin
                        mem_rd_n   = 1'b1;
                        mem_addr_n = ex_addr[ADDR_W+1:2];
                        state_n    = RMW_REQ;
                    end else begin
                        wb_valid_n    = 1'b1;
                        wb_data_n     = ex_addr;
                        wb_rd_n       = ex_rd;
                        wb_regwrite_n = ex_regwrite;
                    end
                end
            end
            LD_REQ:   state_n = LD_WAIT;
            LD_WAIT: begin
                wb_valid_n    = 1'b1;
                wb_data_n     = load_ext;
                wb_rd_n       = op_rd;
                wb_regwrite_n = op_regwrite;
                state_n       = IDLE;
            end
            RMW_REQ:  state_n = RMW_WAIT;
            // Memory data is valid now; write the merged word back next cycle.
            RMW_WAIT: begin
                mem_wr_n    = 1'b1;
                mem_wdata_n = merged;
                wb_valid_n  = 1'b1;
                wb_data_n   = op_addr;
                wb_rd_n     = op_rd;
                state_n     = RMW_WR;
            end
            RMW_WR:   state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!res) begin
            state       <= IDLE;
            op_addr     <= '0;
            op_size     <= '0;
            op_unsigned <= 1'b0;
            op_wdata    <= '0;
            op_rd       <= '0;
            op_regwrite <= 1'b0;
            mem_wr      <= 1'b0;
            mem_rd      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            wb_valid    <= 1'b0;
            wb_data     <= '0;
            wb_rd       <= '0;
            wb_regwrite <= 1'b0;
            wb_fault    <= 1'b0;
        end else begin
            state       <= state_n;
            op_addr     <= op_addr_n;
            op_size     <= op_size_n;
            op_unsigned <= op_unsigned_n;
            op_wdata    <= op_wdata_n;
            op_rd       <= op_rd_n;
            op_regwrite <= op_regwrite_n;
            mem_wr      <= mem_wr_n;
            mem_rd      <= mem_rd_n;
            mem_addr    <= mem_addr_n;
            mem_wdata   <= mem_wdata_n;
            wb_valid    <= wb_valid_n;
            wb_data     <= wb_data_n;
            wb_rd       <= wb_rd_n;
            wb_regwrite <= wb_regwrite_n;
            wb_fault    <= wb_fault_n;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a behavioural 64-word memory plus scoreboards
// of expected MEM/WB results and memory writes, checked as the DUT produces them.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        res;
    logic        in_valid, in_ready;
    logic        ex_memrd, ex_memwr, ex_unsigned, ex_regwrite;
    logic [1:0]  ex_size;
    logic [31:0] ex_addr, ex_wdata;
    logic [4:0]  ex_rd;
    logic        mem_wr, mem_rd;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        wb_valid, wb_regwrite, wb_fault;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;

    typedef struct {
        logic [31:0] data;
        logic        chk_data;
        logic [4:0]  rd;
        logic        regwrite;
        logic        fault;
        int          lat;
        int          acc;
    } wb_exp_t;

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] data;
    } wr_exp_t;

    wb_exp_t     sbq[$];
    wr_exp_t     wq[$];
    logic [31:0] mem [0:63];
    int          cyc = 0;
    int          checks = 0;
    int          passed = 0;
    int          fails = 0;

    mem_access_unit #(.ADDR_W(6), .DATA_W(32)) dut (
        .clk(clk), .res(res), .in_valid(in_valid), .in_ready(in_ready),
        .ex_memrd(ex_memrd), .ex_memwr(ex_memwr), .ex_size(ex_size),
        .ex_unsigned(ex_unsigned), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
        .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
        .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
        .wb_regwrite(wb_regwrite), .wb_fault(wb_fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_rd) mem_rdata <= mem[mem_addr];
        if (mem_wr) mem[mem_addr] <= mem_wdata;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Results and writes are compared against the queues as they appear.
    always @(negedge clk) begin
        wb_exp_t e;
        wr_exp_t w;
        checkOutput("strobe_exclusive", {31'b0, mem_rd & mem_wr}, 32'd0);
        if (wb_valid) begin
            if (sbq.size() == 0) checkOutput("wb_unexpected", {31'b0, wb_valid}, 32'd0);
            else begin
                e = sbq.pop_front();
                if (e.chk_data) checkOutput("wb_data", wb_data, e.data);
                if (e.regwrite) checkOutput("wb_rd", {27'b0, wb_rd}, {27'b0, e.rd});
                checkOutput("wb_regwrite", {31'b0, wb_regwrite}, {31'b0, e.regwrite});
                checkOutput("wb_fault", {31'b0, wb_fault}, {31'b0, e.fault});
                checkOutput("wb_latency", cyc - e.acc, e.lat);
            end
        end
        if (mem_wr) begin
            if (wq.size() == 0) checkOutput("wr_unexpected", {31'b0, mem_wr}, 32'd0);
            else begin
                w = wq.pop_front();
                checkOutput("mem_addr", {26'b0, mem_addr}, {26'b0, w.addr});
                checkOutput("mem_wdata", mem_wdata, w.data);
            end
        end
    end

    task automatic expectWrite(input logic [5:0] addr, input logic [31:0] data);
        wr_exp_t w;
        w.addr = addr;
        w.data = data;
        wq.push_back(w);
    endtask

    task automatic applyStimulus(input logic rdop, input logic wrop, input logic [1:0] size,
                                 input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [4:0] rd, input logic rw,
                                 input logic [31:0] exp_data, input logic chk_data,
                                 input logic exp_rw, input logic exp_fault, input int lat);
        wb_exp_t e;
        int n;
        @(negedge clk);
        ex_memrd = rdop; ex_memwr = wrop; ex_size = size; ex_unsigned = uns;
        ex_addr = addr; ex_wdata = wdata; ex_rd = rd; ex_regwrite = rw;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("ready_wait", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        e.data = exp_data; e.chk_data = chk_data; e.rd = rd; e.regwrite = exp_rw;
        e.fault = exp_fault; e.lat = lat; e.acc = cyc;
        sbq.push_back(e);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        res = 1'b0; in_valid = 1'b0; ex_memrd = 1'b0; ex_memwr = 1'b0; ex_size = 2'b00;
        ex_unsigned = 1'b0; ex_addr = '0; ex_wdata = '0; ex_rd = '0; ex_regwrite = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("rst_strobes", {30'b0, mem_rd, mem_wr}, 32'd0);
        checkOutput("rst_wb", {29'b0, wb_valid, wb_regwrite, wb_fault}, 32'd0);
        checkOutput("rst_wb_data", wb_data, 32'd0);
        checkOutput("rst_mem_addr", {26'b0, mem_addr}, 32'd0);
        res = 1'b1;

        // Back-to-back word stores, then seed word 5 for the loads.
        expectWrite(6'd5, 32'h0000_0009);
        expectWrite(6'd4, 32'h0000_0001);
        applyStimulus(0, 1, 2'b10, 0, 32'h14, 32'h9, 5'd1, 1, 32'h0, 0, 0, 0, 0);
        checkOutput("sw_ready_b2b", {31'b0, in_ready}, 32'd1);
        applyStimulus(0, 1, 2'b10, 0, 32'h10, 32'h1, 5'd1, 1, 32'h0, 0, 0, 0, 0);
        expectWrite(6'd5, 32'h80F1_7F09);
        applyStimulus(0, 1, 2'b10, 0, 32'h14, 32'h80F1_7F09, 5'd2, 0, 32'h0, 0, 0, 0, 0);

        // Word load with handshake/strobe timing.
        applyStimulus(1, 0, 2'b10, 0, 32'h14, 32'h0, 5'd3, 1, 32'h80F1_7F09, 1, 1, 0, 2);
        checkOutput("lw_rd_e0", {30'b0, mem_rd, in_ready}, 32'b10);
        @(posedge clk); #1;
        checkOutput("lw_rd_e1", {30'b0, mem_rd, in_ready}, 32'b00);
        @(posedge clk); #1;
        checkOutput("lw_ready_e2", {30'b0, mem_rd, in_ready}, 32'b01);

        applyStimulus(1, 0, 2'b00, 0, 32'h17, 32'h0, 5'd4, 1, 32'hFFFF_FF80, 1, 1, 0, 2);
        applyStimulus(1, 0, 2'b00, 1, 32'h17, 32'h0, 5'd5, 1, 32'h0000_0080, 1, 1, 0, 2);
        applyStimulus(1, 0, 2'b01, 0, 32'h16, 32'h0, 5'd6, 1, 32'hFFFF_80F1, 1, 1, 0, 2);
        applyStimulus(1, 0, 2'b00, 0, 32'h15, 32'h0, 5'd7, 1, 32'h0000_007F, 1, 1, 0, 2);
        applyStimulus(1, 0, 2'b01, 1, 32'h14, 32'h0, 5'd8, 1, 32'h0000_7F09, 1, 1, 0, 2);

        // Sub-word stores via read-modify-write.
        expectWrite(6'd5, 32'h80AB_7F09);
        applyStimulus(0, 1, 2'b00, 0, 32'h16, 32'h1234_56AB, 5'd9, 1, 32'h0, 0, 0, 0, 2);
        applyStimulus(1, 0, 2'b10, 0, 32'h14, 32'h0, 5'd10, 1, 32'h80AB_7F09, 1, 1, 0, 2);
        expectWrite(6'd5, 32'h80AB_1234);
        applyStimulus(0, 1, 2'b01, 0, 32'h14, 32'hFFFF_1234, 5'd11, 1, 32'h0, 0, 0, 0, 2);
        applyStimulus(1, 0, 2'b10, 0, 32'h14, 32'h0, 5'd12, 1, 32'h80AB_1234, 1, 1, 0, 2);

        // Faults: single edge, no strobes.
        applyStimulus(1, 0, 2'b10, 0, 32'h12, 32'h0, 5'd13, 1, 32'h12, 1, 0, 1, 0);
        checkOutput("flt_lw_strobe", {30'b0, mem_rd, mem_wr}, 32'd0);
        applyStimulus(0, 1, 2'b01, 0, 32'h11, 32'h5, 5'd14, 1, 32'h11, 1, 0, 1, 0);
        checkOutput("flt_sh_strobe", {30'b0, mem_rd, mem_wr}, 32'd0);
        applyStimulus(1, 0, 2'b10, 0, 32'h100, 32'h0, 5'd15, 1, 32'h100, 1, 0, 1, 0);
        checkOutput("flt_range_strobe", {30'b0, mem_rd, mem_wr}, 32'd0);
        applyStimulus(1, 1, 2'b10, 0, 32'h8, 32'h0, 5'd16, 1, 32'h8, 1, 0, 1, 0);
        checkOutput("flt_rdwr_strobe", {30'b0, mem_rd, mem_wr}, 32'd0);
        applyStimulus(1, 0, 2'b11, 0, 32'h4, 32'h0, 5'd17, 1, 32'h4, 1, 0, 1, 0);
        checkOutput("flt_size_strobe", {30'b0, mem_rd, mem_wr}, 32'd0);

        // Non-memory ops issue one per cycle.
        applyStimulus(0, 0, 2'b10, 0, 32'h3C, 32'h0, 5'd18, 1, 32'h3C, 1, 1, 0, 0);
        applyStimulus(0, 0, 2'b10, 0, 32'hC5, 32'h0, 5'd19, 1, 32'hC5, 1, 1, 0, 0);

        // Reset during LD_WAIT abandons the load.
        @(negedge clk);
        ex_memrd = 1'b1; ex_memwr = 1'b0; ex_size = 2'b10; ex_addr = 32'h14;
        ex_rd = 5'd20; ex_regwrite = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        res = 1'b0;
        @(posedge clk); #1;
        checkOutput("rstmid_outputs", {28'b0, wb_valid, mem_rd, mem_wr, wb_fault}, 32'd0);
        checkOutput("rstmid_ready", {31'b0, in_ready}, 32'd1);
        res = 1'b1;
        applyStimulus(0, 0, 2'b00, 0, 32'h2A, 32'h0, 5'd21, 1, 32'h2A, 1, 1, 0, 0);

        n = 0;
        while ((sbq.size() != 0 || wq.size() != 0) && n < 30) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        checkOutput("sb_drain", sbq.size(), 32'd0);
        checkOutput("wr_drain", wq.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
